// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and helpers for the 7-segment scan decoder.
//   scan_state_t : per-dwell FSM state (idle / settling / holding a sample)
//   SEG_LUT      : active-low segment pattern of digits 0..9, bit0=a .. bit6=g
//   seg_to_bcd   : pattern -> {legal, nibble}; anything outside the table is illegal
//   bcd_pair     : tens/ones nibbles -> binary 0..99 (7 b)
package seg_scan_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} scan_state_t;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 10; i++)
      if (seg == SEG_LUT[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction

  // tens*10 as two shifts and an add, no multiplier
  function automatic logic [6:0] bcd_pair(input logic [3:0] t, input logic [3:0] o);
    logic [6:0] tw;
    tw = {3'b000, t};
    return (tw << 3) + (tw << 1) + {3'b000, o};
  endfunction

endpackage

// File: rtl/seg_blank_timer.sv
// seg_blank_timer: per-digit saturating "time since last good sample" counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : a legal sample of this digit was taken; restart from 0
//   expire   : counter has reached TIMEOUT-1 (held until the next clr)
module seg_blank_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)      cnt <= '0;
    else if (cnt != LAST) cnt <= cnt + W'(1);
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 4 digits of a multiplexed, active-low
// 7-segment MM:SS display from its scan lines, publishes minutes/seconds once
// a full frame has been captured, flags blanked digits and illegal patterns.
//   clk, rst     : clock, synchronous active-high reset
//   seg_in[6:0]  : segments, active low, bit0=a .. bit6=g
//   an_in[3:0]   : anodes, active low; 0=sec ones, 1=sec tens, 2=min ones, 3=min tens
//   digits_bcd   : {min_tens, min_ones, sec_tens, sec_ones}
//   digit_valid  : digit holds a legal, non-stale sample
//   blank        : digit not seen lit within BLANK_TIMEOUT cycles
//   minutes/seconds : binary values, updated with frame_valid only
//   frame_valid  : 1-cycle pulse, new minutes/seconds published
//   decode_err   : 1-cycle pulse, illegal pattern / multi-anode / tens > 5
//   err_digit    : digit index of the most recent error
// Optional (SEG_SCAN_STATS_EN defined): frame_count, err_count, saturating.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int BLANK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits_bcd,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        frame_valid,
  output logic        decode_err,
  output logic [1:0]  err_digit
`ifdef SEG_SCAN_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam int NUM_DIG = 4;
  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  scan_state_t state, state_nx;
  logic [CW-1:0] settle_cnt, cnt_nx;
  logic [NUM_DIG-1:0] captured;

  logic [3:0] an_act;
  logic       an_idle, an_single, an_multi, an_chg, seg_chg;
  logic [1:0] act_idx;
  logic       do_sample, multi_err;
  logic [4:0] dec;
  logic       samp_bad;
  logic [NUM_DIG-1:0] clr, expire;
  logic [NUM_DIG-1:0][3:0] nib;
  logic       frame_chk, frame_bad;
  logic [1:0] frame_idx;
  logic [6:0] min_bin, sec_bin;
  logic       unused_bits;

  // anode classification on the registered copy
  always_comb begin
    an_act    = ~an_q;
    an_idle   = (an_act == 4'd0);
    an_single = !an_idle && ((an_act & (an_act - 4'd1)) == 4'd0);
    an_multi  = !an_idle && !an_single;
    act_idx   = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (an_act[i]) act_idx = 2'(i);
  end

  assign an_chg  = (an_q != an_d);
  assign seg_chg = (seg_q != seg_d);

  // A multi-anode pattern is reported once, on the cycle it appears, not for
  // every cycle it persists.
  always_comb begin
    state_nx  = state;
    cnt_nx    = settle_cnt;
    do_sample = 1'b0;
    multi_err = 1'b0;
    if (an_multi && an_chg) begin
      multi_err = 1'b1;
      state_nx  = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (an_single) begin
            state_nx = S_SETTLE;
            cnt_nx   = '0;
          end
        end
        S_SETTLE: begin
          if (an_chg) begin
            state_nx = an_single ? S_SETTLE : S_IDLE;
            cnt_nx   = '0;
          end else if (seg_chg) begin
            cnt_nx = '0;
          end else if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
            do_sample = 1'b1;
            state_nx  = S_HOLD;
          end else begin
            cnt_nx = settle_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          // seg changes are ignored here; only a new anode ends the dwell
          if (an_chg) begin
            state_nx = an_single ? S_SETTLE : S_IDLE;
            cnt_nx   = '0;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign dec      = seg_to_bcd(seg_q);
  assign samp_bad = do_sample && !dec[4];

  // frame check runs on the cycle after the 4th capture
  assign frame_chk = (captured == 4'hF);
  assign frame_bad = frame_chk && ((nib[1] > 4'd5) || (nib[3] > 4'd5));
  assign frame_idx = (nib[3] > 4'd5) ? 2'd3 : 2'd1;
  assign min_bin   = bcd_pair(nib[3], nib[2]);
  assign sec_bin   = bcd_pair(nib[1], nib[0]);
  assign unused_bits = ^{min_bin[6], sec_bin[6]};

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    logic [3:0] nib_r;
    logic       vld_r, blk_r;

    assign clr[k] = do_sample && dec[4] && (act_idx == 2'(k));

    seg_blank_timer #(.TIMEOUT(BLANK_TIMEOUT)) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr[k]),
      .expire (expire[k])
    );

    // nibble is kept across blanking so a blinking digit still reads back
    always_ff @(posedge clk) begin
      if (rst) begin
        nib_r <= '0;
        vld_r <= 1'b0;
        blk_r <= 1'b0;
      end else if (clr[k]) begin
        nib_r <= dec[3:0];
        vld_r <= 1'b1;
        blk_r <= 1'b0;
      end else if (expire[k]) begin
        vld_r <= 1'b0;
        blk_r <= 1'b1;
      end
    end

    assign nib[k]         = nib_r;
    assign digit_valid[k] = vld_r;
    assign blank[k]       = blk_r;
  end

  assign digits_bcd = nib;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= 7'h7F;
      seg_d       <= 7'h7F;
      an_q        <= 4'hF;
      an_d        <= 4'hF;
      state       <= S_IDLE;
      settle_cnt  <= '0;
      captured    <= '0;
      minutes     <= '0;
      seconds     <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      err_digit   <= '0;
    end else begin
      seg_q       <= seg_in;
      an_q        <= an_in;
      seg_d       <= seg_q;
      an_d        <= an_q;
      state       <= state_nx;
      settle_cnt  <= cnt_nx;
      captured    <= (frame_chk ? 4'h0 : captured) | clr;
      frame_valid <= frame_chk && !frame_bad;
      decode_err  <= multi_err || samp_bad || frame_bad;
      // frame-check index wins when both kinds of error land together
      if (frame_bad)                  err_digit <= frame_idx;
      else if (multi_err || samp_bad) err_digit <= act_idx;
      if (frame_chk && !frame_bad) begin
        minutes <= min_bin[5:0];
        seconds <= sec_bin[5:0];
      end
    end
  end

`ifdef SEG_SCAN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_valid && (frame_count != 16'hFFFF)) frame_count <= frame_count + 16'd1;
      if (decode_err && (err_count != 16'hFFFF))    err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TMO    = 2000;

  // standard active-high lit-segment codes (a=bit0); the display drives the inverse
  localparam logic [6:0] LIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_valid, blank;
  logic [5:0]  minutes, seconds;
  logic        frame_valid, decode_err;
  logic [1:0]  err_digit;
`ifdef SEG_SCAN_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .BLANK_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_bcd  (digits_bcd),
    .digit_valid (digit_valid),
    .blank       (blank),
    .minutes     (minutes),
    .seconds     (seconds),
    .frame_valid (frame_valid),
    .decode_err  (decode_err),
    .err_digit   (err_digit)
`ifdef SEG_SCAN_STATS_EN
    ,
    .frame_count (frame_count),
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit fr;
    int edig;
    int mins;
    int secs;
    int digs;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int   m_nib [4];
  bit   m_seen[4];
  int   m_last[4];
  bit   m_cap [4];
  int   m_min, m_sec, m_frames, m_errs, m_rst_cyc;
  logic [3:0] m_prev_an;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) @cyc %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    return ~LIT[d];
  endfunction

  function automatic int low_idx(input logic [3:0] an);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (!an[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] multi_an();
    logic [3:0] a;
    do a = 4'($urandom); while ($countones(~a) < 2);
    return a;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_nib[k] = 0; m_seen[k] = 0; m_last[k] = 0; m_cap[k] = 0;
    end
    m_min = 0; m_sec = 0; m_frames = 0; m_errs = 0;
    m_prev_an = 4'hF; m_rst_cyc = cyc;
    q.delete();
  endtask

  task automatic push_err(input int d);
    exp_t e;
    e.fr = 0; e.edig = d; e.mins = m_min; e.secs = m_sec; e.digs = 0;
    q.push_back(e);
    m_errs++;
  endtask

  task automatic m_sample(input int k, input logic [6:0] seg);
    int v;
    exp_t e;
    v = -1;
    for (int d = 0; d < 10; d++) if (seg == enc(d)) v = d;
    if (v < 0) begin
      push_err(k);
    end else begin
      m_nib[k] = v; m_seen[k] = 1; m_last[k] = cyc + SETTLE + 1; m_cap[k] = 1;
      if (m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3]) begin
        for (int i = 0; i < 4; i++) m_cap[i] = 0;
        if (m_nib[3] > 5)      push_err(3);
        else if (m_nib[1] > 5) push_err(1);
        else begin
          m_min = m_nib[3] * 10 + m_nib[2];
          m_sec = m_nib[1] * 10 + m_nib[0];
          e.fr = 1; e.edig = 0; e.mins = m_min; e.secs = m_sec;
          e.digs = (m_nib[3] << 12) | (m_nib[2] << 8) | (m_nib[1] << 4) | m_nib[0];
          q.push_back(e);
          m_frames++;
        end
      end
    end
  endtask

  // a stretch of constant pins: samples iff it lasts SETTLE+1 clock edges
  task automatic model_dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    int n;
    n = $countones(~an);
    if (n >= 2) begin
      if (an != m_prev_an) push_err(low_idx(an));
    end else if (n == 1 && len >= SETTLE + 1) begin
      m_sample(low_idx(an), seg);
    end
    m_prev_an = an;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    model_dwell(an, seg, len);
    an_in = an;
    seg_in = seg;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0, input int len);
    dwell(4'b0111, enc(d3), len);
    dwell(4'b1011, enc(d2), len);
    dwell(4'b1101, enc(d1), len);
    dwell(4'b1110, enc(d0), len);
  endtask

  function automatic int exp_valid();
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (m_seen[k] && (cyc - m_last[k]) < TMO) r |= (1 << k);
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits_bcd"},  32'(digits_bcd), 0);
    chk({tag, "_digit_valid"}, 32'(digit_valid), 0);
    chk({tag, "_blank"},       32'(blank), 0);
    chk({tag, "_minutes"},     32'(minutes), 0);
    chk({tag, "_seconds"},     32'(seconds), 0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 0);
    chk({tag, "_decode_err"},  32'(decode_err), 0);
    chk({tag, "_err_digit"},   32'(err_digit), 0);
  endtask

  // scoreboard monitor: every output event consumes one expected entry
  always @(negedge clk) begin
    if (!rst && (frame_valid || decode_err)) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: frame_valid=%0b decode_err=%0b err_digit=%0d min=%0d sec=%0d, nothing expected @cyc %0d",
                 frame_valid, decode_err, err_digit, minutes, seconds, cyc);
      end else begin
        me = q.pop_front();
        chk("ev_frame_valid", 32'(frame_valid), me.fr ? 1 : 0);
        chk("ev_decode_err",  32'(decode_err),  me.fr ? 0 : 1);
        chk("ev_minutes",     32'(minutes), me.mins);
        chk("ev_seconds",     32'(seconds), me.secs);
        if (me.fr) chk("ev_digits_bcd", 32'(digits_bcd), me.digs);
        else       chk("ev_err_digit",  32'(err_digit), me.edig);
      end
    end
  end

  initial begin
    rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    m_reset();

    // nominal "12:34" scans
    scan(1, 2, 3, 4, 40);
    chk("valid_after_first_scan", 32'(digit_valid), exp_valid());
    scan(1, 2, 3, 4, 40);

    // settle boundary: 16 stable edges must not sample, 17 must
    dwell(4'b0111, enc(5), SETTLE);
    dwell(4'b1011, enc(6), 30);
    dwell(4'b1101, enc(3), 30);
    dwell(4'b1110, enc(2), 30);
    dwell(4'b0111, enc(4), SETTLE + 1);
    dwell(4'hF, 7'h7F, 10);

    // glitch on seg at cycle 10 of a dwell restarts the settle
    dwell(4'b0111, enc(8), 10);
    dwell(4'b0111, enc(1), 30);
    dwell(4'b1011, enc(0), 30);
    dwell(4'b1101, enc(3), 12);
    dwell(4'b1101, enc(5), 30);
    dwell(4'b1110, enc(9), 30);

    // all-off on digit 2, then complete the frame
    dwell(4'b0111, enc(2), 30);
    dwell(4'b1011, 7'h7F, 30);
    dwell(4'b1101, enc(1), 30);
    dwell(4'b1110, enc(7), 30);
    chk("valid_after_alloff", 32'(digit_valid), exp_valid());
    dwell(4'b1011, enc(3), 30);

    // two anodes at once
    dwell(4'b1100, enc(8), 20);
    dwell(4'hF, 7'h7F, 5);

    // tens range errors, then recover
    scan(0, 7, 7, 5, 30);
    scan(7, 0, 7, 0, 30);
    scan(4, 4, 4, 4, 30);

    // randomized scans
    for (int s = 0; s < 40; s++) begin
      int dv[4];
      logic [6:0] sg;
      logic [3:0] an;
      dv[3] = ($urandom_range(0, 7) == 0) ? 6 + $urandom_range(0, 3) : $urandom_range(0, 5);
      dv[2] = $urandom_range(0, 9);
      dv[1] = ($urandom_range(0, 7) == 0) ? 6 + $urandom_range(0, 3) : $urandom_range(0, 5);
      dv[0] = $urandom_range(0, 9);
      for (int k = 3; k >= 0; k--) begin
        an = 4'hF;
        an[k] = 1'b0;
        sg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : enc(dv[k]);
        if ($urandom_range(0, 5) == 0)
          dwell(an, sg ^ 7'($urandom_range(1, 127)), $urandom_range(3, SETTLE - 2));
        dwell(an, sg, $urandom_range(SETTLE + 3, SETTLE + 14));
        if ($urandom_range(0, 7) == 0)       dwell(4'hF, 7'h7F, $urandom_range(1, 5));
        else if ($urandom_range(0, 14) == 0) dwell(multi_an(), 7'($urandom), $urandom_range(2, 8));
      end
    end

    // digit 3 stops being driven long enough to be declared blank
    scan(1, 2, 3, 4, 30);
    for (int r = 0; r < 30; r++) begin
      dwell(4'b1011, enc(5), 30);
      dwell(4'b1101, enc(0), 30);
      dwell(4'b1110, enc(9), 30);
    end
    chk("blank_digit3_off", 32'(blank), 4'b1000);
    chk("valid_digit3_off", 32'(digit_valid), exp_valid());
    dwell(4'b0111, enc(2), 30);
    dwell(4'hF, 7'h7F, 5);
    chk("blank_restored", 32'(blank), 0);
    chk("valid_restored", 32'(digit_valid), 4'hF);

    // reset in the middle of a settle
    dwell(4'hF, 7'h7F, 30);
    an_in = 4'b1110; seg_in = enc(9);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    chk_reset_outputs("midrst");
`ifdef SEG_SCAN_STATS_EN
    chk("midrst_frame_count", 32'(frame_count), 0);
    chk("midrst_err_count",   32'(err_count), 0);
`endif
    model_dwell(4'b1110, enc(9), 30);
    repeat (30) @(posedge clk);
    #1;
    dwell(4'b0111, enc(0), 30);
    dwell(4'b1011, enc(1), 30);
    dwell(4'b1101, enc(5), 30);
    scan(1, 2, 3, 4, 30);
    scan(5, 9, 0, 0, 30);
    scan(0, 7, 7, 5, 30);
    dwell(4'hF, 7'h7F, 40);
`ifdef SEG_SCAN_STATS_EN
    chk("frame_count", 32'(frame_count), m_frames);
    chk("err_count",   32'(err_count), m_errs);
`endif
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
